// File: rtl/fade_sequencer.sv
// Blend-weight fade sequencer: ramps a 3-bit weight one step every FRAMES_PER_STEP
// frame ticks. Optional macro FADE_AUTO_RETURN_EN enables timed return from HOLD_B.
module fade_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned FRAME_Y         = 480,
  parameter int unsigned HOLD_FRAMES     = 120
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       istart,
  input  logic [9:0] inow_x,
  input  logic [9:0] inow_y,
  output logic [2:0] oTrans,
  output logic       oSlt,
  output logic       oBusy,
  output logic       oDone,
  output logic [1:0] oState
);

  localparam int unsigned CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

  if ((FRAMES_PER_STEP == 0) || (HOLD_FRAMES == 0)) begin : g_param_check
    $error("fade_sequencer: FRAMES_PER_STEP and HOLD_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE_A    = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD_B    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_trans;
  logic [2:0]    w_trans_nxt;
  logic          r_slt;
  logic          r_busy;
  logic          r_done;
  logic          w_done_nxt;
  logic          r_match_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_match;
  logic          w_tick;
  logic          w_step;

  // One tick per frame: rising edge of the blanking-line coordinate match
  assign w_match = (inow_x == 10'd0) && (inow_y == 10'(FRAME_Y));
  assign w_tick  = w_match & ~r_match_d;
  assign w_step  = w_tick && (r_cnt == CNT_LAST);

`ifdef FADE_AUTO_RETURN_EN
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_trans_nxt = r_trans;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
`ifdef FADE_AUTO_RETURN_EN
    w_hold_nxt  = r_hold;
`endif
    if (w_tick) begin
      w_cnt_nxt = w_step ? '0 : CW'(r_cnt + 1'b1);
    end
    case (r_state)
      IDLE_A: begin
        w_trans_nxt = 3'd0;
        if (istart) w_state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (istart) begin
          w_state_nxt = RAMP_DOWN;
        end else if (w_step) begin
          if (r_trans >= 3'd6) begin
            w_trans_nxt = 3'd7;
            w_state_nxt = HOLD_B;
            w_done_nxt  = 1'b1;
`ifdef FADE_AUTO_RETURN_EN
            w_hold_nxt  = '0;
`endif
          end else begin
            w_trans_nxt = r_trans + 3'd1;
          end
        end
      end
      HOLD_B: begin
        w_trans_nxt = 3'd7;
        if (istart) begin
          w_state_nxt = RAMP_DOWN;
        end
`ifdef FADE_AUTO_RETURN_EN
        // Timed return behaves exactly like an istart in HOLD_B
        else if (w_tick) begin
          if (r_hold == HOLD_LAST) begin
            w_state_nxt = RAMP_DOWN;
            w_cnt_nxt   = '0;
          end else begin
            w_hold_nxt  = HW'(r_hold + 1'b1);
          end
        end
`endif
      end
      RAMP_DOWN: begin
        if (istart) begin
          w_state_nxt = RAMP_UP;
        end else if (w_step) begin
          if (r_trans <= 3'd1) begin
            w_trans_nxt = 3'd0;
            w_state_nxt = IDLE_A;
            w_done_nxt  = 1'b1;
          end else begin
            w_trans_nxt = r_trans - 3'd1;
          end
        end
      end
      default: w_state_nxt = IDLE_A;
    endcase
    // istart wins over a coincident step and restarts the frame count
    if (istart) w_cnt_nxt = '0;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state   <= IDLE_A;
      r_trans   <= 3'd0;
      r_slt     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match_d <= 1'b0;
      r_cnt     <= '0;
`ifdef FADE_AUTO_RETURN_EN
      r_hold    <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_trans   <= w_trans_nxt;
      r_slt     <= (w_state_nxt == IDLE_A);
      r_busy    <= (w_state_nxt == RAMP_UP) || (w_state_nxt == RAMP_DOWN);
      r_done    <= w_done_nxt;
      r_match_d <= w_match;
      r_cnt     <= w_cnt_nxt;
`ifdef FADE_AUTO_RETURN_EN
      r_hold    <= w_hold_nxt;
`endif
    end
  end

  assign oTrans = r_trans;
  assign oSlt   = r_slt;
  assign oBusy  = r_busy;
  assign oDone  = r_done;
  assign oState = r_state;

endmodule

// File: tb/tb_fade_sequencer.sv
// Scoreboard bench for fade_sequencer: main instance with FRAMES_PER_STEP=2,
// second instance with FRAMES_PER_STEP=1 for the tick de-glitch scenario.
module tb_fade_sequencer;

  typedef struct {
    logic [2:0] trans;
    logic [1:0] state;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       irst = 1'b0;
  logic       istart = 1'b0;
  logic       istart1 = 1'b0;
  logic [9:0] inow_x = 10'd1;
  logic [9:0] inow_y = 10'd0;
  logic [2:0] trans, trans1;
  logic       slt, slt1, busy, busy1, done, done1;
  logic [1:0] state, state1;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fade_sequencer #(.FRAMES_PER_STEP(2), .FRAME_Y(480), .HOLD_FRAMES(3)) dut (
    .iclk(clk), .irst(irst), .istart(istart), .inow_x(inow_x), .inow_y(inow_y),
    .oTrans(trans), .oSlt(slt), .oBusy(busy), .oDone(done), .oState(state)
  );

  fade_sequencer #(.FRAMES_PER_STEP(1), .FRAME_Y(480), .HOLD_FRAMES(3)) dut1 (
    .iclk(clk), .irst(irst), .istart(istart1), .inow_x(inow_x), .inow_y(inow_y),
    .oTrans(trans1), .oSlt(slt1), .oBusy(busy1), .oDone(done1), .oState(state1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_hi();
    inow_x = 10'd0;
    inow_y = 10'd480;
    cyc();
  endtask

  task automatic tick_lo();
    inow_x = 10'd7;
    inow_y = 10'd12;
    cyc();
  endtask

  task automatic apply_reset();
    istart = 1'b0;
    istart1 = 1'b0;
    irst = 1'b1;
    cyc();
    cyc();
    irst = 1'b0;
  endtask

  task automatic pulse_start();
    istart = 1'b1;
    cyc();
    istart = 1'b0;
  endtask

  task automatic test_reset();
    istart = 1'b0;
    irst = 1'b1;
    cyc();
    cyc();
    n_tests++; if (trans !== 3'd0) begin n_fail++; $display("FAIL reset_trans got %0d want 0", trans); end
    n_tests++; if (slt !== 1'b1)   begin n_fail++; $display("FAIL reset_slt got %b want 1", slt); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    irst = 1'b0;
    tick_lo();
  endtask

  task automatic test_fade_up();
    exp_t e;
    pulse_start();
    n_tests++; if (state !== 2'd1 || slt !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL up_start state/slt/busy got %0d/%b/%b want 1/0/1", state, slt, busy);
    end
    for (int k = 1; k <= 14; k++) begin
      q.push_back('{trans: 3'(k / 2), state: (k == 14) ? 2'd2 : 2'd1, done: (k == 14)});
      tick_hi();
      e = q.pop_front();
      n_tests++; if (trans !== e.trans || state !== e.state || done !== e.done) begin
        n_fail++; $display("FAIL up_tick%0d trans/state/done got %0d/%0d/%b want %0d/%0d/%b",
                           k, trans, state, done, e.trans, e.state, e.done);
      end
      tick_lo();
    end
    n_tests++; if (done !== 1'b0 || slt !== 1'b0 || busy !== 1'b0 || trans !== 3'd7) begin
      n_fail++; $display("FAIL up_hold done/slt/busy/trans got %b/%b/%b/%0d want 0/0/0/7", done, slt, busy, trans);
    end
  endtask

  task automatic test_reverse();
    exp_t e;
    apply_reset();
    pulse_start();
    for (int k = 1; k <= 6; k++) begin tick_hi(); tick_lo(); end
    n_tests++; if (trans !== 3'd3) begin n_fail++; $display("FAIL rev_pre trans got %0d want 3", trans); end
    pulse_start();
    n_tests++; if (state !== 2'd3 || trans !== 3'd3 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL rev_flip state/trans/busy/done got %0d/%0d/%b/%b want 3/3/1/0", state, trans, busy, done);
    end
    for (int k = 1; k <= 6; k++) begin
      q.push_back('{trans: 3'(3 - k / 2), state: (k == 6) ? 2'd0 : 2'd3, done: (k == 6)});
      tick_hi();
      e = q.pop_front();
      n_tests++; if (trans !== e.trans || state !== e.state || done !== e.done) begin
        n_fail++; $display("FAIL rev_tick%0d trans/state/done got %0d/%0d/%b want %0d/%0d/%b",
                           k, trans, state, done, e.trans, e.state, e.done);
      end
      if (k == 6) begin
        n_tests++; if (slt !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL rev_end slt/busy got %b/%b want 1/0", slt, busy);
        end
      end
      tick_lo();
    end
  endtask

  task automatic test_deglitch();
    apply_reset();
    tick_lo();
    istart1 = 1'b1;
    cyc();
    istart1 = 1'b0;
    inow_x = 10'd0;
    inow_y = 10'd480;
    for (int c = 0; c < 10; c++) cyc();
    n_tests++; if (trans1 !== 3'd1 || state1 !== 2'd1 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL deglitch trans/state/busy got %0d/%0d/%b want 1/1/1", trans1, state1, busy1);
    end
    n_tests++; if (slt1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL deglitch slt/done got %b/%b want 0/0", slt1, done1);
    end
    tick_lo();
  endtask

  task automatic test_collision();
    apply_reset();
    pulse_start();
    for (int k = 1; k <= 11; k++) begin tick_hi(); tick_lo(); end
    n_tests++; if (trans !== 3'd5) begin n_fail++; $display("FAIL coll_pre trans got %0d want 5", trans); end
    istart = 1'b1;
    tick_hi();
    istart = 1'b0;
    n_tests++; if (trans !== 3'd5 || state !== 2'd3 || done !== 1'b0) begin
      n_fail++; $display("FAIL coll_edge trans/state/done got %0d/%0d/%b want 5/3/0", trans, state, done);
    end
    tick_lo();
    tick_hi(); tick_lo();
    n_tests++; if (trans !== 3'd5) begin n_fail++; $display("FAIL coll_cntclr trans got %0d want 5", trans); end
    tick_hi(); tick_lo();
    n_tests++; if (trans !== 3'd4 || state !== 2'd3) begin
      n_fail++; $display("FAIL coll_step trans/state got %0d/%0d want 4/3", trans, state);
    end
  endtask

  task automatic test_reset_mid_ramp();
    apply_reset();
    pulse_start();
    for (int k = 1; k <= 8; k++) begin tick_hi(); tick_lo(); end
    n_tests++; if (trans !== 3'd4) begin n_fail++; $display("FAIL midrst_pre trans got %0d want 4", trans); end
    irst = 1'b1;
    istart = 1'b1;
    cyc();
    n_tests++; if (trans !== 3'd0 || slt !== 1'b1 || busy !== 1'b0 || state !== 2'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midrst trans/slt/busy/state/done got %0d/%b/%b/%0d/%b want 0/1/0/0/0",
                         trans, slt, busy, state, done);
    end
    istart = 1'b0;
    irst = 1'b0;
    cyc();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL midrst_after state got %0d want 0", state); end
  endtask

  task automatic test_hold();
    apply_reset();
    pulse_start();
    for (int k = 1; k <= 14; k++) begin tick_hi(); tick_lo(); end
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL hold_entry state got %0d want 2", state); end
`ifdef FADE_AUTO_RETURN_EN
    for (int k = 1; k <= 3; k++) begin
      q.push_back('{trans: 3'd7, state: (k == 3) ? 2'd3 : 2'd2, done: 1'b0});
      tick_hi();
      begin
        exp_t e;
        e = q.pop_front();
        n_tests++; if (state !== e.state || trans !== e.trans) begin
          n_fail++; $display("FAIL auto_tick%0d state/trans got %0d/%0d want %0d/%0d", k, state, trans, e.state, e.trans);
        end
      end
      tick_lo();
    end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL auto_busy got %b want 1", busy); end
`else
    for (int k = 1; k <= 5; k++) begin tick_hi(); tick_lo(); end
    n_tests++; if (state !== 2'd2 || trans !== 3'd7 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_persist state/trans/busy got %0d/%0d/%b want 2/7/0", state, trans, busy);
    end
    pulse_start();
    n_tests++; if (state !== 2'd3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_exit state/busy got %0d/%b want 3/1", state, busy);
    end
`endif
  endtask

  initial begin
    cyc();
    test_reset();
    test_fade_up();
    test_reverse();
    test_deglitch();
    test_collision();
    test_reset_mid_ramp();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
